// File: rtl/mem_lane_ctrl.sv
// Byte-lane SRAM controller: valid/ready request, registered one-cycle response, lane enables, load extension.
// Define MEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they respond with resp_err.
module mem_lane_ctrl #(
    parameter int XLEN     = 32,
    parameter int NBYTES   = 4,
    parameter int SRAM_LAT = 1,
    localparam int LW      = $clog2(NBYTES),
    localparam int AW      = XLEN - LW
) (
    input  logic              memclk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [AW-1:0]     sram_addr,
    output logic [NBYTES-1:0] sram_en,
    output logic              sram_we,
    output logic [XLEN-1:0]   sram_wdata,
    input  logic [XLEN-1:0]   sram_rdata
);

`ifdef MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam int MW  = 2 * NBYTES;
    localparam int WCW = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                beat_q, beat_d;
    logic [WCW-1:0]      wcnt_q, wcnt_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [2*XLEN-1:0]   cap_q, cap_d;
    logic [NBYTES-1:0]   sram_en_q, sram_en_d;
    logic                sram_we_q, sram_we_d;
    logic [AW-1:0]       sram_addr_q, sram_addr_d;
    logic [XLEN-1:0]     sram_wdata_q, sram_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;

    logic                idle, accept, issue, issue_hi, has_hi;
    logic                cur_write;
    logic [1:0]          cur_size;
    logic [XLEN-1:0]     cur_addr, cur_wdata, wdata_rot, ld_raw, load_data;
    logic [LW-1:0]       cur_off;
    logic [AW-1:0]       cur_word;
    logic [MW-1:0]       base_mask, mask2;
    logic [NBYTES-1:0]   mask_lo, mask_hi;

    assign idle      = (state_q == S_IDLE);
    assign req_ready = idle & rstn;
    assign accept    = req_valid & req_ready;

    // In IDLE the first beat is computed straight from the request so ISSUE outputs can be registered at accept.
    assign cur_write = idle ? req_write : write_q;
    assign cur_size  = idle ? req_size  : size_q;
    assign cur_addr  = idle ? req_addr  : addr_q;
    assign cur_wdata = idle ? req_wdata : wdata_q;
    assign cur_off   = cur_addr[LW-1:0];
    assign cur_word  = cur_addr[XLEN-1:LW];
    assign wdata_rot = XLEN'({cur_wdata, cur_wdata} >> (8 * (NBYTES - int'(cur_off))));

    always_comb begin
        case (cur_size)
            2'b00:   base_mask = MW'(1);
            2'b01:   base_mask = MW'(3);
            default: base_mask = {{NBYTES{1'b0}}, {NBYTES{1'b1}}};
        endcase
        mask2 = base_mask << cur_off;
    end

    assign mask_lo = mask2[NBYTES-1:0];
    assign mask_hi = mask2[MW-1:NBYTES];
    assign has_hi  = |mask_hi;

    // Beat0 lands in the low half of the capture register, beat1 in the high half.
    always_comb begin
        cap_d = cap_q;
        if (accept) begin
            cap_d = '0;
        end else if (state_q == S_WAIT && wcnt_q == '0) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (!beat_q && mask_lo[i]) cap_d[i*8 +: 8] = sram_rdata[i*8 +: 8];
                if (beat_q && mask_hi[i])  cap_d[XLEN + i*8 +: 8] = sram_rdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        ld_raw = XLEN'(cap_d >> (8 * int'(addr_q[LW-1:0])));
        case (size_q)
            2'b00:   load_data = {{(XLEN-8){signed_q & ld_raw[7]}}, ld_raw[7:0]};
            2'b01:   load_data = {{(XLEN-16){signed_q & ld_raw[15]}}, ld_raw[15:0]};
            default: load_data = ld_raw;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        wcnt_d       = wcnt_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        issue        = 1'b0;
        issue_hi     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    beat_d   = 1'b0;
                    if (req_size == 2'b11 || (has_hi && !SPLIT_EN)) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        issue   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!write_q) begin
                    state_d = S_WAIT;
                    wcnt_d  = WCW'(SRAM_LAT - 1);
                end else if (!beat_q && has_hi) begin
                    beat_d   = 1'b1;
                    issue    = 1'b1;
                    issue_hi = 1'b1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCW'(1);
                end else if (!beat_q && has_hi) begin
                    beat_d   = 1'b1;
                    state_d  = S_ISSUE;
                    issue    = 1'b1;
                    issue_hi = 1'b1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sram_en_d    = '0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (issue) begin
            sram_en_d    = issue_hi ? mask_hi : mask_lo;
            sram_we_d    = cur_write;
            sram_addr_d  = issue_hi ? cur_word + AW'(1) : cur_word;
            sram_wdata_d = wdata_rot;
        end
    end

    always_ff @(posedge memclk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            beat_q       <= 1'b0;
            wcnt_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cap_q        <= '0;
            sram_en_q    <= '0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wcnt_q       <= wcnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cap_q        <= cap_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Directed bench for mem_lane_ctrl with a behavioural SRAM, a response scoreboard and an SRAM beat log.
module tb_mem_lane_ctrl;
    localparam int LAT = 1;

    logic        memclk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] sram_addr;
    logic [3:0]  sram_en;
    logic        sram_we;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'd0;

    mem_lane_ctrl #(.XLEN(32), .NBYTES(4), .SRAM_LAT(LAT)) dut (
        .memclk(memclk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 memclk = ~memclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge memclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Behavioural SRAM: reads return data LAT=1 cycle after the enable, random data otherwise.
    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge memclk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem_ready <= 1'b1;
        end else if (sram_en != 4'b0 && sram_we) begin
            mem[sram_addr[5:0]] <= merge(mem[sram_addr[5:0]], sram_wdata, sram_en);
        end
        if (sram_en != 4'b0 && !sram_we) sram_rdata <= mem[sram_addr[5:0]];
        else                             sram_rdata <= $urandom;
    end

    typedef struct { logic [31:0] rd; logic err; int c; } sb_t;
    typedef struct { logic [3:0] en; logic [29:0] addr; logic we; logic [31:0] wd; int c; } beat_t;
    sb_t   sb[$];
    beat_t beats[$];
    sb_t   e;

    always @(negedge memclk) begin
        if (sram_en != 4'b0) beats.push_back('{sram_en, sram_addr, sram_we, sram_wdata, cyc});
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input int nb, input logic [3:0] en0, input logic [29:0] ad0,
                        input logic [3:0] en1, input logic [29:0] ad1, input logic [31:0] exp_wd);
        int t0;
        @(negedge memclk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("resp_pulse_low", 32'(resp_valid), 32'd0);
        beats.delete();
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        t0 = cyc;
        sb.push_back('{exp_rd, exp_err, t0 + lat});
        @(posedge memclk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom_range(3)); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int i = 0; i < 40; i++) begin
            @(negedge memclk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("resp_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        chk("beat_count", 32'(beats.size()), 32'(nb));
        for (int k = 0; k < nb && k < beats.size(); k++) begin
            chk("beat_en", 32'(beats[k].en), 32'(k == 0 ? en0 : en1));
            chk("beat_addr", 32'(beats[k].addr), 32'(k == 0 ? ad0 : ad1));
            chk("beat_we", 32'(beats[k].we), 32'(wr));
            if (wr) chk("beat_wdata", beats[k].wd, exp_wd);
            chk("beat_cycle", 32'(beats[k].c), 32'(t0 + 1 + k * (wr ? 1 : 1 + LAT)));
        end
    endtask

    initial begin
        repeat (3) @(negedge memclk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        rstn = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // aligned stores and loads, extension variants
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'hDEADBEEF);
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h80000000, 32'h0, 1'b0, 2, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'h80000000);
        xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2 + LAT, 1, 4'h8, 30'd4, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 2 + LAT, 1, 4'h8, 30'd4, 4'h0, 30'd0, 32'h0);
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hABCD0000, 32'h0, 1'b0, 2, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'hABCD0000);
        xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000ABCD, 1'b0, 2 + LAT, 1, 4'hC, 30'd4, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFFABCD, 1'b0, 2 + LAT, 1, 4'hC, 30'd4, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hABCD0000, 1'b0, 2 + LAT, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0000CD00, 1'b0, 2 + LAT, 1, 4'h6, 30'd4, 4'h0, 30'd0, 32'h0);
        // sub-word stores with lane rotation
        xact(1'b1, 2'd0, 1'b0, 32'h21, 32'h123456A5, 32'h0, 1'b0, 2, 1, 4'h2, 30'd8, 4'h0, 30'd0, 32'h3456A512);
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hC0DEA508, 1'b0, 2 + LAT, 1, 4'hF, 30'd8, 4'h0, 30'd0, 32'h0);
        xact(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, 2, 1, 4'hC, 30'd8, 4'h0, 30'd0, 32'h1234FFFF);
        xact(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h00000012, 1'b0, 2 + LAT, 1, 4'h8, 30'd8, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'hFFFFA508, 1'b0, 2 + LAT, 1, 4'h3, 30'd8, 4'h0, 30'd0, 32'h0);
        // illegal size
        xact(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 4'h0, 30'd0, 4'h0, 30'd0, 32'h0);
        xact(1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1, 1, 0, 4'h0, 30'd0, 4'h0, 30'd0, 32'h0);
        // word-crossing accesses
        xact(1'b1, 2'd2, 1'b0, 32'h0C, 32'h44330000, 32'h0, 1'b0, 2, 1, 4'hF, 30'd3, 4'h0, 30'd0, 32'h44330000);
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h00006655, 32'h0, 1'b0, 2, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'h00006655);
`ifdef MEM_MISALIGN_SPLIT_EN
        xact(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h66554433, 1'b0, 3 + 2*LAT, 2, 4'hC, 30'd3, 4'h3, 30'd4, 32'h0);
        xact(1'b1, 2'd1, 1'b0, 32'h0F, 32'h0000BEEF, 32'h0, 1'b0, 3, 2, 4'h8, 30'd3, 4'h1, 30'd4, 32'hEF0000BE);
        xact(1'b0, 2'd1, 1'b1, 32'h0F, 32'h0, 32'hFFFFBEEF, 1'b0, 3 + 2*LAT, 2, 4'h8, 30'd3, 4'h1, 30'd4, 32'h0);
        xact(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00007711, 32'h0, 1'b0, 3, 2, 4'h8, 30'h3FFFFFFF, 4'h1, 30'd0, 32'h11000077);
        xact(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h00000011, 1'b0, 2 + LAT, 1, 4'h8, 30'h3FFFFFFF, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd0, 1'b0, 32'h00, 32'h0, 32'h00000077, 1'b0, 2 + LAT, 1, 4'h1, 30'd0, 4'h0, 30'd0, 32'h0);
`else
        xact(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1, 0, 4'h0, 30'd0, 4'h0, 30'd0, 32'h0);
        xact(1'b1, 2'd1, 1'b0, 32'h0F, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 4'h0, 30'd0, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd1, 1'b1, 32'h0F, 32'h0, 32'h0, 1'b1, 1, 0, 4'h0, 30'd0, 4'h0, 30'd0, 32'h0);
        xact(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00007711, 32'h0, 1'b1, 1, 0, 4'h0, 30'd0, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h000000C0, 1'b0, 2 + LAT, 1, 4'h8, 30'h3FFFFFFF, 4'h0, 30'd0, 32'h0);
        xact(1'b0, 2'd0, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0, 2 + LAT, 1, 4'h1, 30'd0, 4'h0, 30'd0, 32'h0);
`endif

        // reset while waiting on read data abandons the load
        @(negedge memclk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
        @(posedge memclk);
        #1;
        req_valid = 1'b0;
        @(negedge memclk);
        chk("abort_issue_en", 32'(sram_en), 32'hF);
        @(negedge memclk);
        rstn = 1'b0;
        @(negedge memclk);
        chk("abort_sram_en", 32'(sram_en), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_sram_addr", 32'(sram_addr), 32'd0);
        @(negedge memclk);
        rstn = 1'b1;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        repeat (4) @(negedge memclk);

`ifdef MEM_MISALIGN_SPLIT_EN
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h000066BE, 1'b0, 2 + LAT, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'h0);
`else
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h00006655, 1'b0, 2 + LAT, 1, 4'hF, 30'd4, 4'h0, 30'd0, 32'h0);
`endif
        repeat (3) @(negedge memclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
